// File: rtl/pl_adc_capture.sv
// -----------------------------------------------------------------------------
// pl_adc_capture
//
// Capture engine for the parallel CMOS ADC bus. After a work request it
// registers the ADC bus on every clock, keeps one sample in every Decim+1,
// and pushes the kept samples into a first-word-fall-through FIFO. The FIFO
// head leaves on a valid/ready stream. When the programmed number of samples
// has been kept and the FIFO has drained, o_ADC_Done is raised as a level
// handshake. It stays high until the controller drops i_ADC_Work.
//
// Ports
//   i_CMOS_Clk     in   1        ADC data clock, the only clock
//   i_Reset        in   1        synchronous, active-high reset
//   i_CMOS_Data    in   DATA_W   raw ADC bus
//   i_ADC_Work     in   1        level work request; dropping it mid-run aborts
//   i_Num_Samples  in   COUNT_W  samples to keep, latched at start
//   i_Decim        in   DEC_W    keep 1 of i_Decim+1 samples, latched at start
//   o_Data         out  DATA_W   FIFO head (0 while the FIFO is empty)
//   o_Valid        out  1        FIFO non-empty
//   i_Ready        in   1        consumer accepts o_Data on this edge
//   o_ADC_Done     out  1        capture complete
//   o_Busy         out  1        capturing or draining
//   o_Overflow     out  1        sticky: a kept sample hit a full FIFO
// -----------------------------------------------------------------------------
module pl_adc_capture #(
    parameter int DATA_W     = 12,
    parameter int COUNT_W    = 20,
    parameter int DEC_W      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               i_CMOS_Clk,
    input  logic               i_Reset,
    input  logic [DATA_W-1:0]  i_CMOS_Data,
    input  logic               i_ADC_Work,
    input  logic [COUNT_W-1:0] i_Num_Samples,
    input  logic [DEC_W-1:0]   i_Decim,
    output logic [DATA_W-1:0]  o_Data,
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic               o_ADC_Done,
    output logic               o_Busy,
    output logic               o_Overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [COUNT_W-1:0] KEPT_ONE = COUNT_W'(1);
    localparam logic [DEC_W-1:0]   DEC_ONE  = DEC_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Run configuration, latched on the IDLE -> CAPTURE edge
    logic [COUNT_W-1:0] target;
    logic [DEC_W-1:0]   dec_reload;

    // Run progress
    logic [COUNT_W-1:0] kept_cnt;
    logic [DEC_W-1:0]   dec_cnt;

    // Input stage: registered ADC bus plus a flag marking a kept sample
    logic [DATA_W-1:0]  data_p0;
    logic               vld_p0;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic               ovf;
    logic               flush;
    logic               target_hit;
    logic               keep;
    logic               fifo_empty;
    logic               fifo_full;
    logic               wr_en;
    logic               rd_en;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_FULL);
        // Dropping the work request while a run is in flight is an abort
        flush      = ((state == CAPTURE) || (state == DRAIN)) && !i_ADC_Work;
        target_hit = (kept_cnt == target);
        keep       = (state == CAPTURE) && !flush && (dec_cnt == '0) && !target_hit;
        // A kept sample arriving at a full FIFO is lost, even if a read
        // frees a slot on the same edge
        wr_en      = vld_p0 && (state == CAPTURE) && !flush && !fifo_full;
        rd_en      = !fifo_empty && i_Ready && !flush;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_ADC_Work) begin
                    // A zero-length request completes without capturing
                    state_nxt = (i_Num_Samples == '0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (!i_ADC_Work) begin
                    state_nxt = IDLE;
                end else if (target_hit && !vld_p0) begin
                    // Last kept sample has left the input stage
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_ADC_Work) begin
                    state_nxt = IDLE;
                end else if (fifo_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_ADC_Work) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_ADC_Done = 1'b0;
        o_Busy     = 1'b0;
        case (state)
            CAPTURE: o_Busy     = 1'b1;
            DRAIN:   o_Busy     = 1'b1;
            DONE:    o_ADC_Done = 1'b1;
            default: begin
                o_ADC_Done = 1'b0;
                o_Busy     = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Run counters and overflow flag
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset) begin
            target     <= '0;
            dec_reload <= '0;
            kept_cnt   <= '0;
            dec_cnt    <= '0;
            vld_p0     <= 1'b0;
            ovf        <= 1'b0;
        end else if ((state == IDLE) && i_ADC_Work) begin
            target     <= i_Num_Samples;
            dec_reload <= i_Decim;
            kept_cnt   <= '0;
            // Zero here makes the very first captured sample a kept one
            dec_cnt    <= '0;
            vld_p0     <= 1'b0;
            ovf        <= 1'b0;
        end else if ((state == CAPTURE) && !flush) begin
            vld_p0 <= keep;
            if (dec_cnt == '0) begin
                dec_cnt <= dec_reload;
                // Counter stops at the target so it can never wrap in a run
                if (!target_hit) begin
                    kept_cnt <= kept_cnt + KEPT_ONE;
                end
            end else begin
                dec_cnt <= dec_cnt - DEC_ONE;
            end
            if (vld_p0 && fifo_full) begin
                ovf <= 1'b1;
            end
        end else begin
            // Abort keeps ovf so the controller can still read it
            vld_p0 <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p0: input register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CMOS_Clk) begin
        if (state == CAPTURE) begin
            data_p0 <= i_CMOS_Data;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: FIFO write / read
    // -------------------------------------------------------------------------
    always_ff @(posedge i_CMOS_Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_p0;
        end
    end

    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // First-word-fall-through head; forced to zero while empty so the
    // stream bus is quiet after reset and after a flush
    always_comb begin
        o_Valid    = !fifo_empty;
        o_Data     = fifo_empty ? '0 : mem[rd_ptr];
        o_Overflow = ovf;
    end

endmodule

// File: tb/tb_pl_adc_capture.sv
module tb_pl_adc_capture;

    localparam int DATA_W  = 12;
    localparam int COUNT_W = 20;
    localparam int DEC_W   = 8;
    localparam int DEPTH   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  din;
    logic               work;
    logic [COUNT_W-1:0] num;
    logic [DEC_W-1:0]   dec;
    logic [DATA_W-1:0]  o_data;
    logic               o_valid;
    logic               ready;
    logic               o_done;
    logic               o_busy;
    logic               o_ovf;

    always #5 clk = ~clk;

    pl_adc_capture #(
        .DATA_W     (DATA_W),
        .COUNT_W    (COUNT_W),
        .DEC_W      (DEC_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_CMOS_Clk    (clk),
        .i_Reset       (rst),
        .i_CMOS_Data   (din),
        .i_ADC_Work    (work),
        .i_Num_Samples (num),
        .i_Decim       (dec),
        .o_Data        (o_data),
        .o_Valid       (o_valid),
        .i_Ready       (ready),
        .o_ADC_Done    (o_done),
        .o_Busy        (o_busy),
        .o_Overflow    (o_ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, expressed as a timeline: edge E0 starts a run and
    // t counts edges since E0. Sample k (0-based) is taken at edge
    // 1+k(D+1), lands in the FIFO one edge later, and the run moves to
    // draining one edge after the final write.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

    int                m_st = M_IDLE;
    int unsigned       m_t, m_n, m_d;
    logic [DATA_W-1:0] q[$];
    logic              m_ovf = 1'b0;
    bit                pend_v = 1'b0;
    logic [DATA_W-1:0] pend_d;
    logic [DATA_W-1:0] beats[$];

    // Stimulus modes applied after every edge
    bit data_ramp = 1'b1;
    bit rnd_ready = 1'b0;
    int ready_pct = 50;

    task automatic model_edge();
        int pre;
        int nst;
        if (rst) begin
            m_st = M_IDLE;
            q.delete();
            m_ovf = 1'b0;
            pend_v = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (work) begin
                        if (num == '0) begin
                            m_st = M_DONE;
                        end else begin
                            m_st = M_CAP;
                            m_t = 0;
                            m_n = num;
                            m_d = dec;
                            m_ovf = 1'b0;
                            pend_v = 1'b0;
                        end
                    end
                end
                M_CAP, M_DRAIN: begin
                    if (!work) begin
                        q.delete();
                        pend_v = 1'b0;
                        m_st = M_IDLE;
                    end else begin
                        pre = q.size();
                        nst = m_st;
                        if (m_st == M_DRAIN && pre == 0) nst = M_DONE;
                        if (pre > 0 && ready) void'(q.pop_front());
                        if (pend_v) begin
                            if (pre == DEPTH) m_ovf = 1'b1;
                            else q.push_back(pend_d);
                            pend_v = 1'b0;
                        end
                        if (m_st == M_CAP) begin
                            m_t++;
                            if (((m_t - 1) % (m_d + 1)) == 0 && ((m_t - 1) / (m_d + 1)) < m_n) begin
                                pend_v = 1'b1;
                                pend_d = din;
                            end
                            if (m_t == (m_n - 1) * (m_d + 1) + 3) nst = M_DRAIN;
                        end
                        m_st = nst;
                    end
                end
                default: begin
                    if (!work) m_st = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare();
        chk("valid", o_valid, q.size() > 0);
        chk("data", o_data, (q.size() > 0) ? q[0] : '0);
        chk("done", o_done, m_st == M_DONE);
        chk("busy", o_busy, (m_st == M_CAP) || (m_st == M_DRAIN));
        chk("ovf", o_ovf, m_ovf);
    endtask

    task automatic tick();
        bit beat;
        logic [DATA_W-1:0] bd;
        beat = (o_valid === 1'b1) && ready;
        bd = o_data;
        @(posedge clk);
        if (beat && !rst) beats.push_back(bd);
        model_edge();
        #1;
        compare();
        if (data_ramp) din = din + 1'b1;
        else din = DATA_W'($urandom);
        if (rnd_ready) ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    // Raises work for edge E0; the sample registered at E1 is 0 in ramp mode
    task automatic start(input int n, input int d);
        num = COUNT_W'(n);
        dec = DEC_W'(d);
        work = 1'b1;
        beats.delete();
        tick();
        if (data_ramp) din = '0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (o_done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("done_reached", o_done, 1'b1);
    endtask

    task automatic finish_run();
        work = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; work = 1'b0; ready = 1'b0; din = '0; num = '0; dec = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 12'h000);
        chk("rst_done", o_done, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ovf", o_ovf, 1'b0);

        // N=8, D=0, consumer always ready, ramp data
        ready = 1'b1;
        start(8, 0);
        wait_done(100);
        chk("n8_beats", beats.size(), 8);
        for (int i = 0; i < beats.size() && i < 8; i++) chk("n8_beat", beats[i], i);
        chk("n8_ovf", o_ovf, 1'b0);
        repeat (3) tick();
        chk("n8_done_hold", o_done, 1'b1);
        work = 1'b0;
        tick();
        chk("n8_done_fall", o_done, 1'b0);
        tick();

        // N=4, D=2: every third sample
        start(4, 2);
        wait_done(100);
        chk("n4d2_beats", beats.size(), 4);
        for (int i = 0; i < beats.size() && i < 4; i++) chk("n4d2_beat", beats[i], 3 * i);
        finish_run();

        // N=20 with a stalled consumer: 16 retained, 4 dropped
        ready = 1'b0;
        start(20, 0);
        repeat (30) tick();
        chk("ovf_busy_stalled", o_busy, 1'b1);
        ready = 1'b1;
        wait_done(100);
        chk("ovf_beats", beats.size(), 16);
        for (int i = 0; i < beats.size() && i < 16; i++) chk("ovf_beat", beats[i], i);
        chk("ovf_flag", o_ovf, 1'b1);
        finish_run();

        // Abort after 3 of 10 samples
        ready = 1'b0;
        start(10, 0);
        repeat (3) tick();
        work = 1'b0;
        tick();
        chk("abort_valid", o_valid, 1'b0);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_done", o_done, 1'b0);
        repeat (5) tick();
        chk("abort_done_later", o_done, 1'b0);

        // Zero-length request
        ready = 1'b1;
        start(0, 0);
        chk("n0_done", o_done, 1'b1);
        chk("n0_busy", o_busy, 1'b0);
        chk("n0_valid", o_valid, 1'b0);
        finish_run();
        chk("n0_beats", beats.size(), 0);

        // Reset in the middle of a capture with 5 samples queued
        ready = 1'b0;
        start(10, 0);
        repeat (6) tick();
        chk("midrst_pre_valid", o_valid, 1'b1);
        rst = 1'b1;
        work = 1'b0;
        tick();
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_data", o_data, 12'h000);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_done", o_done, 1'b0);
        chk("midrst_ovf", o_ovf, 1'b0);
        rst = 1'b0;
        tick();
        ready = 1'b1;
        start(3, 1);
        wait_done(100);
        chk("postrst_beats", beats.size(), 3);
        for (int i = 0; i < beats.size() && i < 3; i++) chk("postrst_beat", beats[i], 2 * i);
        finish_run();

        // Randomized runs: random data, lengths, decimation, back-pressure, aborts
        data_ramp = 1'b0;
        rnd_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int n, d, abort_at;
            n = $urandom_range(1, 40);
            d = $urandom_range(0, 3);
            ready_pct = $urandom_range(10, 100);
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1;
            start(n, d);
            for (int k = 0; k < 800 && o_done !== 1'b1; k++) begin
                if (k == abort_at) work = 1'b0;
                tick();
                if (work == 1'b0) break;
            end
            if (abort_at < 0) chk("rnd_done", o_done, 1'b1);
            finish_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
